// File: rtl/aes_block_packer.sv
// aes_block_packer: packs a 32-bit word stream into 128-bit AES blocks, issues each block to
// the encryptor as a pulse, tracks blocks through the pipeline with a latency-matched
// valid/last delay line, and changes the key only while no block is in flight.
// Optional feature: define AES_PACK_PAD_EN to let s_last close a short, zero-padded block.
module aes_block_packer #(
    parameter int LATENCY = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  s_data,
    input  logic                         s_valid,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic [127:0]                 pt_data,
    output logic                         pt_valid,
    input  logic [127:0]                 key_in,
    input  logic                         key_load,
    output logic [127:0]                 cipher_key,
    output logic                         key_ack,
    output logic                         ct_valid,
    output logic                         ct_last,
    output logic [$clog2(LATENCY+1)-1:0] inflight
);
    localparam int IW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {FILL, DRAIN, LOAD} state_t;

    state_t         state, state_nxt;
    logic [95:0]    acc;
    logic [1:0]     wcnt;
    logic           accept, issue, blk_last, pt_last_int;
    logic [127:0]   blk;
    logic [127:0]   key_buf;
    logic           key_pend;
    logic [LATENCY-1:0] dl_valid, dl_last;

    assign accept = s_valid && s_ready;
`ifdef AES_PACK_PAD_EN
    assign blk_last = s_last;
`else
    assign blk_last = s_last & 1'b0;
`endif
    assign issue = accept && (wcnt == 2'd3 || blk_last);
    // a short block is left-aligned: older words of a previous block are shifted out the top
    assign blk = {acc, s_data} << {2'd3 - wcnt, 5'd0};
    assign ct_valid = dl_valid[LATENCY-1];
    assign ct_last = dl_last[LATENCY-1];

    // word assembly, issue pulse and held block output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            wcnt <= '0;
            pt_data <= '0;
            pt_valid <= 1'b0;
            pt_last_int <= 1'b0;
        end else begin
            pt_valid <= issue;
            pt_last_int <= issue && blk_last;
            if (accept) begin
                acc <= {acc[63:0], s_data};
                wcnt <= issue ? 2'd0 : wcnt + 2'd1;
            end
            if (issue)
                pt_data <= blk;
        end
    end

    // latency-matched {valid, last} delay line and in-flight block count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_valid <= '0;
            dl_last <= '0;
            inflight <= '0;
        end else begin
            dl_valid <= LATENCY'({dl_valid, pt_valid});
            dl_last <= LATENCY'({dl_last, pt_last_int});
            inflight <= inflight + IW'(pt_valid) - IW'(ct_valid);
        end
    end

    // pending key capture; the committed key changes on entry to LOAD, acked one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_pend <= 1'b0;
            key_buf <= '0;
            cipher_key <= '0;
            key_ack <= 1'b0;
        end else begin
            key_ack <= state == LOAD;
            if (key_load) begin
                key_pend <= 1'b1;
                key_buf <= key_in;
            end else if (state_nxt == LOAD) begin
                key_pend <= 1'b0;
            end
            if (state_nxt == LOAD)
                cipher_key <= key_buf;
        end
    end

    // key sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FILL;
        else
            state <= state_nxt;
    end

    // leave FILL only at a block boundary; LOAD once the pipeline and issue slot are empty
    always_comb begin
        state_nxt = (state == FILL && key_pend && wcnt == 2'd0) ? DRAIN :
                    (state == DRAIN && inflight == '0 && !pt_valid) ? LOAD :
                    (state == LOAD) ? FILL : state;
    end

    // words are accepted only while filling
    always_comb begin
        s_ready = state == FILL;
    end
endmodule

// File: tb/tb_aes_block_packer.sv
// tb_aes_block_packer: table-driven, directed and randomized checks of aes_block_packer.
module tb_aes_block_packer;
    localparam int LAT = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [127:0] pt_data, key_in = '0, cipher_key;
    logic         pt_valid, key_load = 1'b0, key_ack, ct_valid, ct_last;
    logic [3:0]   inflight;

    int total = 0, bad = 0, cyc = 0;

    aes_block_packer #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .pt_data(pt_data), .pt_valid(pt_valid), .key_in(key_in),
        .key_load(key_load), .cipher_key(cipher_key), .key_ack(key_ack),
        .ct_valid(ct_valid), .ct_last(ct_last), .inflight(inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:3][31:0] w;
        bit               gap;
        logic [127:0]     exp;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        tick();
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1);
        chk({tag, "_pt_data"}, pt_data, 0);
        chk({tag, "_pt_valid"}, pt_valid, 0);
        chk({tag, "_cipher_key"}, cipher_key, 0);
        chk({tag, "_key_ack"}, key_ack, 0);
        chk({tag, "_ct_valid"}, ct_valid, 0);
        chk({tag, "_ct_last"}, ct_last, 0);
        chk({tag, "_inflight"}, inflight, 0);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last = 1'b0;
        key_load = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t vecs[4];
    logic [127:0] k1, k2, k3, k4, prev_key;
    logic [31:0]  q[$];
    int           iss[$];
    logic [127:0] exp_data;
    bit           exp_pv, exp_ct, v, dropped, rose, ct_after, ready_drop;
    logic [31:0]  d;
    int           exp_inf, pulses, last_pt, peak, acks, changes;

    initial begin
        vecs[0] = '{'{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff}, 1'b0,
                    128'h00112233_44556677_8899aabb_ccddeeff};
        vecs[1] = '{'{32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'hcafef00d}, 1'b0,
                    128'h01234567_89abcdef_deadbeef_cafef00d};
        vecs[2] = '{'{32'hffffffff, 32'h00000000, 32'h80000001, 32'h7ffffffe}, 1'b1,
                    128'hffffffff_00000000_80000001_7ffffffe};
        vecs[3] = '{'{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001}, 1'b0,
                    128'h00000000_00000000_00000000_00000001};
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        k3 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        k4 = {$urandom, $urandom, $urandom, $urandom};

        rst_n = 1'b1;
        #2;
        s_valid = 1'b1;
        s_data = 32'hbad0bad0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("in_reset");
        do_reset();
        chk_reset_vals("after_reset");

        // table: block assembly, pulse width, hold, and first-block latency
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (vecs[n].gap && i == 2) begin
                    idle(1);
                    chk("gap_pt_valid", pt_valid, 0);
                end
                send_word(vecs[n].w[i], 1'b0);
                if (i < 3) chk("partial_pt_valid", pt_valid, 0);
            end
            chk("vec_pt_valid", pt_valid, 1);
            chk("vec_pt_data", pt_data, vecs[n].exp);
            if (n == 0) begin
                for (int k = 1; k <= LAT; k++) begin
                    tick();
                    chk("lat_ct_valid", ct_valid, k == LAT);
                    chk("lat_inflight_1", inflight, 1);
                end
                tick();
                chk("lat_inflight_0", inflight, 0);
                chk("lat_ct_gone", ct_valid, 0);
            end
            idle(1);
            chk("pulse_one_cycle", pt_valid, 0);
            chk("pt_data_held", pt_data, vecs[n].exp);
        end
        idle(LAT + 2);

        // continuous 16-word stream
        pulses = 0; last_pt = -1; peak = 0; ready_drop = 0;
        for (int i = 0; i < 36; i++) begin
            if (i < 16) begin
                if (!s_ready) ready_drop = 1;
                s_valid = 1'b1;
                s_data = $urandom;
            end else begin
                s_valid = 1'b0;
            end
            tick();
            if (pt_valid) begin
                if (last_pt >= 0) chk("stream_spacing", cyc - last_pt, 4);
                last_pt = cyc;
                pulses++;
            end
            if (int'(inflight) > peak) peak = int'(inflight);
        end
        chk("stream_pulses", pulses, 4);
        chk("stream_ready_drop", ready_drop, 0);
        chk("stream_inflight_peak", peak, 3);
        chk("stream_drained", inflight, 0);
        idle(4);

        // short message with s_last on the second word
        send_word(32'hA1A1A1A1, 1'b0);
        send_word(32'hB2B2B2B2, 1'b1);
`ifdef AES_PACK_PAD_EN
        chk("pad_pt_valid", pt_valid, 1);
        chk("pad_pt_data", pt_data, 128'hA1A1A1A1_B2B2B2B2_00000000_00000000);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            chk("pad_ct_valid", ct_valid, k == LAT);
            if (k == LAT) chk("pad_ct_last", ct_last, 1);
        end
`else
        chk("nopad_pt_valid", pt_valid, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("nopad_wait", pt_valid, 0);
        end
        send_word(32'hC3C3C3C3, 1'b0);
        chk("nopad_3rd", pt_valid, 0);
        send_word(32'hD4D4D4D4, 1'b0);
        chk("nopad_pt_valid", pt_valid, 1);
        chk("nopad_pt_data", pt_data, 128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            chk("nopad_ct_valid", ct_valid, k == LAT);
            if (k == LAT) chk("nopad_ct_last", ct_last, 0);
        end
`endif
        idle(4);

        // key change on empty pipeline, second request overwrites the first
        key_in = k1;
        key_load = 1'b1;
        tick();
        chk("keyA_fill", s_ready, 1);
        key_in = k2;
        tick();
        key_load = 1'b0;
        chk("keyA_drain", s_ready, 0);
        chk("keyA_old_key", cipher_key, 0);
        tick();
        chk("keyA_new_key", cipher_key, k2);
        chk("keyA_no_ack_yet", key_ack, 0);
        chk("keyA_load_ready", s_ready, 0);
        tick();
        chk("keyA_ack", key_ack, 1);
        chk("keyA_ready_back", s_ready, 1);
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (key_ack) acks++;
        end
        chk("keyA_single_ack", acks, 0);
        chk("keyA_key_kept", cipher_key, k2);

        // key change requested mid-block with two blocks in flight
        for (int i = 0; i < 10; i++) send_word($urandom, 1'b0);
        chk("keyB_two_inflight", inflight, 2);
        key_in = k3;
        key_load = 1'b1;
        send_word($urandom, 1'b0);
        key_load = 1'b0;
        chk("keyB_ready_mid", s_ready, 1);
        send_word($urandom, 1'b0);
        chk("keyB_ready_done", s_ready, 1);
        chk("keyB_issue", pt_valid, 1);
        prev_key = cipher_key;
        acks = 0; changes = 0; dropped = 0; rose = 0; ct_after = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (key_ack) acks++;
            if (ct_valid && changes > 0) ct_after = 1;
            if (cipher_key !== prev_key) begin
                changes++;
                chk("keyB_change_empty", inflight, 0);
                chk("keyB_change_ready", s_ready, 0);
                prev_key = cipher_key;
            end
            if (!s_ready) dropped = 1;
            if (s_ready && dropped && !rose) begin
                rose = 1;
                chk("keyB_back_empty", inflight, 0);
                chk("keyB_back_after_change", changes, 1);
            end
        end
        chk("keyB_acks", acks, 1);
        chk("keyB_changes", changes, 1);
        chk("keyB_key", cipher_key, k3);
        chk("keyB_dropped", dropped, 1);
        chk("keyB_ready_end", s_ready, 1);
        chk("keyB_no_ct_after", ct_after, 0);

        // reset with a block in flight and a key pending
        for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
        key_in = k4;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        repeat (4) tick();
        chk("rst_pre_inflight", inflight, 1);
        s_valid = 1'b1;
        s_data = 32'h5a5a5a5a;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        repeat (3) tick();
        chk_reset_vals("held_rst");
        s_valid = 1'b0;
        rst_n = 1'b1;
        acks = 0; ct_after = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (key_ack) acks++;
            if (ct_valid) ct_after = 1;
        end
        chk("rst_no_ct", ct_after, 0);
        chk("rst_no_ack", acks, 0);
        chk("rst_key_zero", cipher_key, 0);
        chk("rst_ready", s_ready, 1);
        send_word(32'h10101010, 1'b0);
        send_word(32'h20202020, 1'b0);
        send_word(32'h30303030, 1'b0);
        send_word(32'h40404040, 1'b0);
        chk("rst_clean_block", pt_data, 128'h10101010_20202020_30303030_40404040);
        chk("rst_clean_valid", pt_valid, 1);

        // randomized stream against a word-queue model
        do_reset();
        q.delete();
        iss.delete();
        for (int c = 0; c < 300; c++) begin
            v = (c < 280) && ($urandom_range(0, 9) < 7);
            d = $urandom;
            s_valid = v;
            s_data = d;
            exp_pv = 0;
            if (v) begin
                q.push_back(d);
                if (q.size() == 4) begin
                    exp_pv = 1;
                    exp_data = {q[0], q[1], q[2], q[3]};
                    q.delete();
                end
            end
            tick();
            if (exp_pv) iss.push_back(cyc);
            chk("rnd_pt_valid", pt_valid, exp_pv);
            if (exp_pv) chk("rnd_pt_data", pt_data, exp_data);
            exp_ct = 0;
            exp_inf = 0;
            foreach (iss[j]) begin
                if (iss[j] + LAT == cyc) exp_ct = 1;
                if (iss[j] < cyc && cyc <= iss[j] + LAT) exp_inf++;
            end
            chk("rnd_ct_valid", ct_valid, exp_ct);
            chk("rnd_inflight", inflight, exp_inf);
            chk("rnd_s_ready", s_ready, 1);
        end
        s_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
